// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: owns the single register-file write port.
// The in-order writeback stage always wins. Results from the long-latency unit
// are buffered in a small FIFO. A writeback to the same register kills any
// older buffered result, so write-after-write order is kept. A live FIFO head
// that waits too long raises a registered stall request.
// Optional statistics outputs are enabled with the macro RF_ARB_STATS_EN.
module rf_wport_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_waddr,
  input  logic [DW-1:0] lu_wdata,
  output logic          lu_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          stall_req
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]   stat_lu_wr,
  output logic [15:0]   stat_kill,
  output logic [15:0]   stat_stall
`endif
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int AGW = $clog2(STARVE_MAX + 1);

  // Entry storage; the live bits sit in a flat vector so every entry can be
  // killed in parallel.
  logic [AW-1:0]         addr_mem [FIFO_DEPTH];
  logic [DW-1:0]         data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_reg, live_next;
  logic [FIFO_DEPTH-1:0] kill_mask;

  // Pointers carry one extra bit so full and empty can be told apart.
  logic [CW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count;
  logic [PW-1:0]  wr_idx, rd_idx;
  logic           full, empty;

  logic [AGW-1:0] age_reg, age_next;
  logic           stall_next;

  logic wb_grant, push_ok, push_store;
  logic head_live, head_dead, head_killed;
  logic pop_live, pop;

  assign wr_idx = wr_ptr_reg[PW-1:0];
  assign rd_idx = rd_ptr_reg[PW-1:0];
  assign count  = wr_ptr_reg - rd_ptr_reg;
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) && (wr_idx == rd_idx);

  // Full is judged before any pop in the same cycle.
  assign lu_ready   = !full && rst;
  assign push_ok    = lu_valid && lu_ready;
  // A result for r0 completes the handshake but is dropped.
  assign push_store = push_ok && (lu_waddr != '0);

  assign wb_grant  = wb_we && (wb_waddr != '0);
  assign head_live = !empty && live_reg[rd_idx];
  assign head_dead = !empty && !live_reg[rd_idx];
  // A live head only goes out when writeback leaves the port free. A dead
  // head uses no write slot, so it is discarded straight away.
  assign pop_live  = head_live && !wb_grant;
  assign pop       = pop_live || head_dead;

  // Per-entry WAW kill: only occupied, still-live entries that match the
  // writeback target. The slot being pushed is unoccupied, so the younger LU
  // result survives.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_kill
      logic [PW-1:0] off;
      logic          occupied;
      assign off          = PW'(gi) - rd_idx;
      assign occupied     = ({1'b0, off} < count);
      assign kill_mask[gi] = wb_grant && occupied && live_reg[gi] &&
                             (addr_mem[gi] == wb_waddr);
    end
  endgenerate

  assign head_killed = kill_mask[rd_idx];

  // Next live vector: apply kills, then mark the newly pushed entry live.
  always_comb begin
    live_next = live_reg;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (kill_mask[i]) live_next[i] = 1'b0;
    end
    if (push_store) live_next[wr_idx] = 1'b1;
  end

  // Age of the head: counts cycles a live head waits, saturating. The stall
  // request also holds for one edge after the starved head leaves.
  always_comb begin
    age_next = age_reg;
    if (!head_live || pop || head_killed) begin
      age_next = '0;
    end else if (age_reg != AGW'(STARVE_MAX)) begin
      age_next = age_reg + 1'b1;
    end
    stall_next = (age_next == AGW'(STARVE_MAX)) || (age_reg == AGW'(STARVE_MAX));
  end

  // FIFO payload write; contents need no reset because occupancy is tracked
  // by the pointers.
  always_ff @(posedge clk) begin
    if (push_store) begin
      addr_mem[wr_idx] <= lu_waddr;
      data_mem[wr_idx] <= lu_wdata;
    end
  end

  // Pointers, live bits, age counter and stall request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      live_reg   <= '0;
      age_reg    <= '0;
      stall_req  <= 1'b0;
    end else begin
      if (push_store) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      live_reg  <= live_next;
      age_reg   <= age_next;
      stall_req <= stall_next;
    end
  end

  // Registered write port: writeback first, then a live FIFO head; address
  // and data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (wb_grant) begin
      rf_we    <= 1'b1;
      rf_waddr <= wb_waddr;
      rf_wdata <= wb_wdata;
    end else if (pop_live) begin
      rf_we    <= 1'b1;
      rf_waddr <= addr_mem[rd_idx];
      rf_wdata <= data_mem[rd_idx];
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef RF_ARB_STATS_EN
  logic [CW-1:0] kill_cnt;
  logic [16:0]   kill_sum;

  // Number of entries killed this cycle; several may match one writeback.
  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      kill_cnt = kill_cnt + CW'(kill_mask[i]);
    end
  end

  assign kill_sum = {1'b0, stat_kill} + 17'(kill_cnt);

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_lu_wr <= '0;
      stat_kill  <= '0;
      stat_stall <= '0;
    end else begin
      if (pop_live && (stat_lu_wr != 16'hFFFF)) stat_lu_wr <= stat_lu_wr + 1'b1;
      stat_kill <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
      if (stall_req && (stat_stall != 16'hFFFF)) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters:
  - the in-order writeback stage (wb_*, no backpressure, highest priority);
  - a long-latency unit (mul/div) that returns results through a valid/ready handshake into an internal FIFO.
- Enforces write-after-write ordering between the two requesters.
- Raises a registered stall request toward pipeline control when a buffered LU result is starved.

Parameters:
- AW, 5, register address width
- DW, 32, data width
- FIFO_DEPTH, 4, LU result buffer entries (power of two, >=2)
- STARVE_MAX, 8, cycles a live FIFO head may wait before stall_req asserts (>=1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- wb_we  in  1  writeback write enable
- wb_waddr  in  AW  writeback destination register
- wb_wdata  in  DW  writeback data
- lu_valid  in  1  LU result valid
- lu_waddr  in  AW  LU destination register
- lu_wdata  in  DW  LU result data
- lu_ready  out  1  FIFO can accept; combinational: !full && rst
- rf_we  out  1  registered regfile write enable
- rf_waddr  out  AW  registered regfile write address
- rf_wdata  out  DW  registered regfile write data
- stall_req  out  1  registered request to freeze the pipeline before writeback

Behaviour:
- Reset (rst==0 at posedge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0.
  - FIFO emptied; age counter cleared; statistics counters cleared.
  - Reset mid-operation discards all pending LU entries without writing them.
  - lu_ready=0 while rst==0.
- Push:
  - An LU result is accepted on a cycle with lu_valid && lu_ready.
  - If lu_waddr==0, the handshake completes but nothing is stored.
  - Push and pop in the same cycle are legal. Full is evaluated before the pop, so lu_ready=0 whenever full.
- Each FIFO entry holds {addr, data, live}. A pushed entry is live=1.
- WAW kill:
  - Triggered on a cycle with wb_we && wb_waddr!=0.
  - Every stored entry with addr==wb_waddr gets live=0 at the clock edge.
  - An entry being pushed in that same cycle is NOT killed: the LU result is the younger write.
- Grant, evaluated each cycle from cycle-N inputs; results appear on rf_* at edge N+1 (latency 1):
  1. wb_we && wb_waddr!=0: rf gets wb_*. The FIFO head is not popped, unless the head is dead; see rule 3.
  2. Otherwise, if the head is live: pop it; rf gets {addr, data}, rf_we=1.
  3. A dead head is popped in any cycle with no rf write; this may happen alongside a wb grant.
  4. Otherwise rf_we=0. rf_waddr/rf_wdata hold their previous values.
- Writes to register 0 are never issued: rf_we=0 for wb_waddr==0.
- Starvation:
  - The age counter increments each cycle a live head exists and is not popped.
  - It clears on pop or when the head becomes dead.
  - It saturates at STARVE_MAX.
  - stall_req is set at the edge where the counter reaches STARVE_MAX, and clears at the edge after the starved head is popped.
- Pipeline-control contract: wb_we=0 while stall_req=1. If wb_we=1 anyway, wb still wins and no data is lost.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an extra pointer bit, so full and empty are distinguishable.

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- When defined, adds three outputs:
  - stat_lu_wr (16 bits): count of LU writes issued to the regfile;
  - stat_kill (16 bits): count of entries killed by WAW;
  - stat_stall (16 bits): count of cycles with stall_req=1.
- All three counters saturate at 16'hFFFF and clear on reset.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle, with rst=0 for 2 cycles and wb_we=1 -> rf_we=0, lu_ready=0, stall_req=0. After rst=1: lu_ready=1, and rf_we follows wb_we one cycle later.
- Push LU {r5, 0xA5A5A5A5} with wb_we=0 -> next edge: rf_we=1, rf_waddr=5, rf_wdata=0xA5A5A5A5.
- Push 4 LU entries back-to-back with wb_we=1 to r1 every cycle -> lu_ready=0 after the 4th push. Fifth lu_valid is held off. When wb_we drops, the entries drain in push order, one per cycle.
- Push LU r7=0x11; next cycle wb writes r7=0x22 -> the LU entry is killed and never written. rf sees only r7=0x22. stat_kill=1 when RF_ARB_STATS_EN is defined.
- STARVE_MAX=8, one live entry, wb_we=1 to r3 continuously -> stall_req rises 8 cycles after the push. Drop wb_we: the entry is written on the next edge, and stall_req falls one edge later.
- Push LU to r0 plus a simultaneous wb write to r0 -> rf_we stays 0 and the FIFO stays empty.
